// File: rtl/pc_pkg.sv
// Shared types and default constants for the fetch-stage PC sequencer.
package pc_pkg;

  typedef enum logic [1:0] {
    SRC_SEQ    = 2'd0,
    SRC_BRANCH = 2'd1,
    SRC_JUMP   = 2'd2,
    SRC_TRAP   = 2'd3
  } pc_src_e;

  localparam int unsigned PC_WIDTH_DEF = 32;
  localparam int unsigned INC_DEF      = 4;

endpackage

// File: rtl/pc_incr.sv
// Sequential-address adder: PC + INC modulo 2^PC_WIDTH (carry discarded).
module pc_incr
  import pc_pkg::*;
#(
  parameter int unsigned PC_WIDTH = PC_WIDTH_DEF,
  parameter int unsigned INC      = INC_DEF
) (
  input  logic [PC_WIDTH-1:0] pc_i,
  output logic [PC_WIDTH-1:0] next_o
);

  assign next_o = pc_i + PC_WIDTH'(INC);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC register with prioritised redirects and a stall-time redirect buffer.
// Optional trap redirect enabled by defining PC_TRAP_EN.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned          PC_WIDTH     = PC_WIDTH_DEF,
  parameter int unsigned          INC          = INC_DEF,
  parameter int unsigned          ALIGN_BITS   = 2,
  parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                jump,
  input  logic [PC_WIDTH-1:0] jump_target,
`ifdef PC_TRAP_EN
  input  logic                trap,
  input  logic [PC_WIDTH-1:0] trap_vector,
`endif
  output logic [PC_WIDTH-1:0] PC,
  output logic [PC_WIDTH-1:0] NexttoPC,
  output logic                redirect_pending,
  output logic                misalign
);

  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = {PC_WIDTH{1'b1}} << ALIGN_BITS;

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] pend_tgt_q, pend_tgt_d;
  logic                pend_valid_q, pend_valid_d;
  logic                misalign_q, misalign_d;
  logic [PC_WIDTH-1:0] seq_pc;

  pc_src_e             req_src;
  logic [PC_WIDTH-1:0] req_tgt;
  logic                req_valid;
  logic                load;
  logic [PC_WIDTH-1:0] load_tgt;

  pc_incr #(
    .PC_WIDTH (PC_WIDTH),
    .INC      (INC)
  ) u_incr (
    .pc_i   (pc_q),
    .next_o (seq_pc)
  );

  // Later assignments override earlier ones: trap > jump > branch.
  always_comb begin
    req_src = SRC_SEQ;
    req_tgt = '0;
    if (branch_taken) begin
      req_src = SRC_BRANCH;
      req_tgt = branch_target;
    end
    if (jump) begin
      req_src = SRC_JUMP;
      req_tgt = jump_target;
    end
`ifdef PC_TRAP_EN
    if (trap) begin
      req_src = SRC_TRAP;
      req_tgt = trap_vector;
    end
`endif
  end

  assign req_valid = (req_src != SRC_SEQ);

  always_comb begin
    pc_d         = pc_q;
    pend_tgt_d   = pend_tgt_q;
    pend_valid_d = pend_valid_q;
    misalign_d   = 1'b0;
    load         = 1'b0;
    load_tgt     = '0;
    if (stall) begin
      if (req_valid) begin
        pend_valid_d = 1'b1;
        pend_tgt_d   = req_tgt;
      end
    end else begin
      pend_valid_d = 1'b0;
      if (req_valid) begin
        load     = 1'b1;
        load_tgt = req_tgt;
      end else if (pend_valid_q) begin
        load     = 1'b1;
        load_tgt = pend_tgt_q;
      end else begin
        pc_d = seq_pc;
      end
    end
    // Raw target is kept in the buffer; alignment is applied only on load into PC.
    if (load) begin
      pc_d       = load_tgt & ALIGN_MASK;
      misalign_d = |(load_tgt & ~ALIGN_MASK);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_VECTOR;
      pend_tgt_q   <= '0;
      pend_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      pend_tgt_q   <= pend_tgt_d;
      pend_valid_q <= pend_valid_d;
      misalign_q   <= misalign_d;
    end
  end

  assign PC               = pc_q;
  assign NexttoPC         = seq_pc;
  assign redirect_pending = pend_valid_q;
  assign misalign         = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: vector table plus reset, trap and 16-bit wrap sequences.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, branch_taken, jump;
  logic [31:0] branch_target, jump_target;
  logic [31:0] PC, NexttoPC;
  logic        redirect_pending, misalign;

  logic        s16_stall, s16_br, s16_jmp;
  logic [15:0] s16_bt, s16_jt;
  logic [15:0] pc16, next16;
  logic        pend16, mis16;

`ifdef PC_TRAP_EN
  logic        trap;
  logic [31:0] trap_vector;
  logic        s16_trap;
  logic [15:0] s16_tv;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .jump             (jump),
    .jump_target      (jump_target),
`ifdef PC_TRAP_EN
    .trap             (trap),
    .trap_vector      (trap_vector),
`endif
    .PC               (PC),
    .NexttoPC         (NexttoPC),
    .redirect_pending (redirect_pending),
    .misalign         (misalign)
  );

  pc_sequencer #(
    .PC_WIDTH (16)
  ) dut16 (
    .clk              (clk),
    .reset            (reset),
    .stall            (s16_stall),
    .branch_taken     (s16_br),
    .branch_target    (s16_bt),
    .jump             (s16_jmp),
    .jump_target      (s16_jt),
`ifdef PC_TRAP_EN
    .trap             (s16_trap),
    .trap_vector      (s16_tv),
`endif
    .PC               (pc16),
    .NexttoPC         (next16),
    .redirect_pending (pend16),
    .misalign         (mis16)
  );

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] bt;
    logic        jmp;
    logic [31:0] jt;
    logic [31:0] pc;
    logic [31:0] nxt;
    logic        pend;
    logic        mis;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; branch_taken = 0; jump = 0;
    branch_target = '0; jump_target = '0;
`ifdef PC_TRAP_EN
    trap = 0; trap_vector = '0;
`endif
  endtask

  function automatic void add(input logic s, input logic b, input logic [31:0] bt,
                              input logic j, input logic [31:0] jt,
                              input logic [31:0] pc, input logic pend, input logic mis);
    vec_t v;
    v.stall = s; v.br = b; v.bt = bt; v.jmp = j; v.jt = jt;
    v.pc = pc; v.nxt = pc + 32'd4; v.pend = pend; v.mis = mis;
    vecs.push_back(v);
  endfunction

  initial begin
    // stall br  bt            jmp jt            -> PC            pend mis
    add(0, 0, 0,            0, 0,            32'h0000_0004, 0, 0);
    add(0, 0, 0,            0, 0,            32'h0000_0008, 0, 0);
    add(0, 0, 0,            0, 0,            32'h0000_000C, 0, 0);
    add(0, 0, 0,            1, 32'h100,      32'h0000_0100, 0, 0);
    add(0, 1, 32'h200,      1, 32'h300,      32'h0000_0300, 0, 0);
    add(0, 0, 0,            1, 32'h40,       32'h0000_0040, 0, 0);
    add(1, 0, 0,            0, 0,            32'h0000_0040, 0, 0);
    add(1, 1, 32'h500,      0, 0,            32'h0000_0040, 1, 0);
    add(1, 0, 0,            0, 0,            32'h0000_0040, 1, 0);
    add(0, 0, 0,            0, 0,            32'h0000_0500, 0, 0);
    add(0, 0, 0,            0, 0,            32'h0000_0504, 0, 0);
    add(0, 0, 0,            1, 32'h40,       32'h0000_0040, 0, 0);
    add(1, 0, 0,            0, 0,            32'h0000_0040, 0, 0);
    add(1, 1, 32'h500,      0, 0,            32'h0000_0040, 1, 0);
    add(1, 0, 0,            0, 0,            32'h0000_0040, 1, 0);
    add(0, 0, 0,            1, 32'h600,      32'h0000_0600, 0, 0);
    add(0, 0, 0,            0, 0,            32'h0000_0604, 0, 0);
    add(0, 0, 0,            1, 32'h1003,     32'h0000_1000, 0, 1);
    add(0, 0, 0,            0, 0,            32'h0000_1004, 0, 0);
    add(1, 0, 0,            1, 32'h2001,     32'h0000_1004, 1, 0);
    add(1, 1, 32'h3000,     0, 0,            32'h0000_1004, 1, 0);
    add(0, 0, 0,            0, 0,            32'h0000_3000, 0, 0);
    add(1, 1, 32'h7006,     0, 0,            32'h0000_3000, 1, 0);
    add(0, 0, 0,            0, 0,            32'h0000_7004, 0, 1);
    add(0, 0, 0,            0, 0,            32'h0000_7008, 0, 0);
    add(0, 0, 0,            1, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 0, 1);
    add(0, 0, 0,            0, 0,            32'h0000_0000, 0, 0);

    clear_inputs();
    s16_stall = 0; s16_br = 0; s16_jmp = 0; s16_bt = '0; s16_jt = '0;
`ifdef PC_TRAP_EN
    s16_trap = 0; s16_tv = '0;
`endif
    reset = 1;
    tick();
    chk("rst_pc", PC, 32'h0);
    chk("rst_next", NexttoPC, 32'h4);
    chk("rst_pend", {31'b0, redirect_pending}, 32'h0);
    chk("rst_mis", {31'b0, misalign}, 32'h0);
    tick();
    chk("rst_hold_pc", PC, 32'h0);
    reset = 0;

    foreach (vecs[i]) begin
      stall = vecs[i].stall; branch_taken = vecs[i].br; branch_target = vecs[i].bt;
      jump = vecs[i].jmp; jump_target = vecs[i].jt;
      tick();
      chk($sformatf("row%0d_pc", i),   PC, vecs[i].pc);
      chk($sformatf("row%0d_next", i), NexttoPC, vecs[i].nxt);
      chk($sformatf("row%0d_pend", i), {31'b0, redirect_pending}, {31'b0, vecs[i].pend});
      chk($sformatf("row%0d_mis", i),  {31'b0, misalign}, {31'b0, vecs[i].mis});
    end

    // Pending redirect discarded by reset, even with stall and a request present.
    clear_inputs();
    stall = 1; branch_taken = 1; branch_target = 32'h900;
    tick();
    chk("prst_pend_set", {31'b0, redirect_pending}, 32'h1);
    jump = 1; jump_target = 32'hA00; reset = 1;
    tick();
    chk("prst_pc", PC, 32'h0);
    chk("prst_pend", {31'b0, redirect_pending}, 32'h0);
    clear_inputs(); reset = 0;
    tick();
    chk("prst_after_pc", PC, 32'h4);
    chk("prst_after_pend", {31'b0, redirect_pending}, 32'h0);

`ifdef PC_TRAP_EN
    jump = 1; jump_target = 32'h100;
    tick();
    chk("trap_pre_pc", PC, 32'h100);
    branch_taken = 1; branch_target = 32'h200; jump_target = 32'h300;
    trap = 1; trap_vector = 32'h80;
    tick();
    chk("trap_prio_pc", PC, 32'h80);
    clear_inputs();
    stall = 1; trap = 1; trap_vector = 32'hC0;
    tick();
    chk("trap_buf_pend", {31'b0, redirect_pending}, 32'h1);
    clear_inputs();
    tick();
    chk("trap_buf_pc", PC, 32'hC0);
    clear_inputs();
`endif

    // 16-bit instance: sequential wrap from 0xFFFC.
    s16_jmp = 1; s16_jt = 16'hFFFC;
    tick();
    chk("w16_pc", {16'b0, pc16}, 32'hFFFC);
    chk("w16_next", {16'b0, next16}, 32'h0);
    s16_jmp = 0;
    tick();
    chk("w16_wrap_pc", {16'b0, pc16}, 32'h0);
    chk("w16_wrap_mis", {31'b0, mis16}, 32'h0);
    chk("w16_wrap_next", {16'b0, next16}, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the fetch stage. It owns the PC register and forms the sequential next address. It selects among sequential, branch, jump and (optionally) trap redirects, and holds the PC under stall. A redirect that arrives during a stall is buffered so it is not lost.

## Interface
Parameters:
- PC_WIDTH, 32, width of PC and all target buses
- INC, 4, sequential increment in bytes
- ALIGN_BITS, 2, number of low PC bits that must be zero
- RESET_VECTOR, 0, PC value loaded on reset (PC_WIDTH bits)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold PC this cycle
- branch_taken  in  1  branch redirect request
- branch_target  in  PC_WIDTH  branch destination
- jump  in  1  jump redirect request
- jump_target  in  PC_WIDTH  jump destination
- trap  in  1  trap redirect request (present only with PC_TRAP_EN)
- trap_vector  in  PC_WIDTH  trap destination (present only with PC_TRAP_EN)
- PC  out  PC_WIDTH  current fetch address, registered
- NexttoPC  out  PC_WIDTH  PC + INC, combinational from PC
- redirect_pending  out  1  a buffered redirect is waiting for stall release
- misalign  out  1  one-cycle pulse: the loaded redirect target had nonzero low bits

## Operation
- Request priority within a cycle: trap > jump > branch > sequential.
- Sequential next: PC + INC, modulo 2^PC_WIDTH; carry discarded, wrap-around is legal.
- No stall, no pending:
  - A redirect loads its target.
  - Otherwise PC loads NexttoPC.
- Stall asserted:
  - PC holds.
  - Any redirect request that cycle is written to the pending buffer (target plus valid).
  - A newer request overwrites an older pending one, regardless of type.
  - redirect_pending is high while the buffer is valid.
- First cycle with stall low and the buffer valid:
  - A fresh redirect in that cycle wins; PC loads it.
  - Otherwise PC loads the pending target.
  - The buffer clears in either case.
- Alignment:
  - Any loaded redirect target has its low ALIGN_BITS bits forced to zero.
  - If any of those bits were set, misalign pulses for the cycle after the load.
  - Sequential updates never assert misalign.
- Reset values:
  - PC = RESET_VECTOR
  - redirect_pending = 0, buffer cleared
  - misalign = 0
  - NexttoPC = RESET_VECTOR + INC
- Reset mid-operation: a pending redirect is discarded. Reset overrides stall and all requests in the same cycle.

## Timing
- Redirect latency is one cycle: request sampled at edge N, PC shows the target after edge N.
- Stall-to-resume: PC changes on the first edge where stall is sampled low.
- misalign is registered. It is high in exactly the cycle in which the aligned target appears on PC.
- No combinational path from the request inputs to PC or redirect_pending. NexttoPC depends only on PC.

## Configuration
- PC_TRAP_EN defined:
  - trap and trap_vector ports exist.
  - Trap has top priority and is buffered under stall like the other redirects.
- PC_TRAP_EN undefined:
  - Both ports are absent.
  - Priority reduces to jump > branch > sequential.
  - All other behaviour is identical.

## Structure
- Shared package pc_pkg holds:
  - the redirect-source enum: SRC_SEQ, SRC_BRANCH, SRC_JUMP, SRC_TRAP
  - default constants PC_WIDTH_DEF and INC_DEF
- One sub-module, pc_incr: parametrised PC_WIDTH adder computing PC + INC. It drives NexttoPC and is the direct generalisation of the fixed +4 adder.
- Top level holds the priority select, pending buffer, align/misalign logic and the PC register.

## Test plan
- Reset then 3 free-running cycles:
  - During reset: PC=0x0, NexttoPC=0x4.
  - After reset: PC goes 0x4, 0x8, 0xC; redirect_pending=0.
- PC=0x100:
  - branch_taken with target 0x200 together with jump to 0x300 → next PC=0x300.
  - With PC_TRAP_EN, adding trap to 0x80 → next PC=0x80.
- Stall held 3 cycles at PC=0x40, branch to 0x500 in stall cycle 2:
  - PC stays 0x40 and redirect_pending=1 from the cycle after the request.
  - First unstalled edge: PC=0x500, redirect_pending=0.
- Same buffered-branch setup, with jump to 0x600 in the release cycle → PC=0x600; the buffered 0x500 is dropped.
- Jump to 0x1003 → PC=0x1000 with misalign=1 for exactly one cycle.
- Boundary cases:
  - PC_WIDTH=16, PC=0xFFFC, no redirect → PC=0x0000.
  - Pending redirect followed by reset → PC=RESET_VECTOR, redirect_pending=0.
